// File: rtl/sseg_digit_scanner_if.sv
// Frame-load and per-digit display signals between the frame source and the scanner.
// load is a 1-cycle strobe with no ready: the scanner accepts every strobe, last one wins.
interface sseg_digit_scanner_if;
   logic        load;
   logic [31:0] value;
   logic [7:0]  dp_mask;
   logic [7:0]  en_mask;
   logic        lzb_en;
   logic [2:0]  active_digit;
   logic [3:0]  num;
   logic        dp_ctrl;
   logic        blank;
   logic        frame_done;
   logic        pending;

   modport master (
      output load, value, dp_mask, en_mask, lzb_en,
      input  active_digit, num, dp_ctrl, blank, frame_done, pending
   );

   modport slave (
      input  load, value, dp_mask, en_mask, lzb_en,
      output active_digit, num, dp_ctrl, blank, frame_done, pending
   );
endinterface

// File: rtl/sseg_digit_scanner.sv
// Seven-segment digit scanner: steps one digit per refresh period over a double-buffered
// 8-digit hex frame with DP/enable masks and optional leading-zero blanking.
module sseg_digit_scanner #(
   parameter int REFRESH_TICKS = 99_999,
   parameter int DIGITS        = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sseg_digit_scanner_if.slave  bus
);

   localparam int             CW   = (REFRESH_TICKS < 2) ? 1 : $clog2(REFRESH_TICKS + 1);
   localparam logic [CW-1:0]  TERM = CW'(REFRESH_TICKS);
   localparam logic [2:0]     LAST = 3'(DIGITS - 1);

   logic [CW-1:0] tick_cnt;
   logic [2:0]    idx;
   logic [31:0]   shd_value, disp_value;
   logic [7:0]    shd_dp, shd_en, disp_dp, disp_en;
   logic          pending_q;

   logic [2:0]    active_digit_q;
   logic [3:0]    num_q;
   logic          dp_ctrl_q, blank_q, frame_done_q;

   logic          tick, wrap;
   logic [2:0]    nxt_idx;
   logic [31:0]   nxt_value;
   logic [7:0]    nxt_dp, nxt_en;
   logic [7:0]    zero_from;
   logic          zero_acc;
   logic          nxt_lz;

   always_comb begin
      tick      = (tick_cnt == TERM);
      wrap      = tick && (idx == LAST);
      nxt_idx   = (idx == LAST) ? 3'd0 : idx + 3'd1;
      nxt_value = disp_value;
      nxt_dp    = disp_dp;
      nxt_en    = disp_en;
      // A load landing on the wrap edge bypasses the shadow and is shown from digit 0.
      if (wrap) begin
         if (bus.load) begin
            nxt_value = bus.value;
            nxt_dp    = bus.dp_mask;
            nxt_en    = bus.en_mask;
         end else if (pending_q) begin
            nxt_value = shd_value;
            nxt_dp    = shd_dp;
            nxt_en    = shd_en;
         end
      end
      zero_acc  = 1'b1;
      zero_from = '0;
      for (int i = 7; i >= 0; i--) begin
         if (i < DIGITS) begin
            zero_acc     = zero_acc & (nxt_value[4*i +: 4] == 4'h0);
            zero_from[i] = zero_acc;
         end
      end
      nxt_lz = bus.lzb_en & (nxt_idx != 3'd0) & zero_from[nxt_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt       <= '0;
         idx            <= '0;
         shd_value      <= '0;
         shd_dp         <= '0;
         shd_en         <= 8'hFF;
         disp_value     <= '0;
         disp_dp        <= '0;
         disp_en        <= 8'hFF;
         pending_q      <= 1'b0;
         active_digit_q <= '0;
         num_q          <= '0;
         dp_ctrl_q      <= 1'b0;
         blank_q        <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         tick_cnt     <= tick ? '0 : tick_cnt + CW'(1);
         frame_done_q <= wrap;
         disp_value   <= nxt_value;
         disp_dp      <= nxt_dp;
         disp_en      <= nxt_en;
         if (bus.load) begin
            shd_value <= bus.value;
            shd_dp    <= bus.dp_mask;
            shd_en    <= bus.en_mask;
            pending_q <= ~wrap;
         end else if (wrap) begin
            pending_q <= 1'b0;
         end
         if (tick) begin
            idx            <= nxt_idx;
            active_digit_q <= nxt_idx;
            num_q          <= nxt_value[{nxt_idx, 2'b00} +: 4];
            dp_ctrl_q      <= nxt_dp[nxt_idx];
            blank_q        <= ~nxt_en[nxt_idx] | nxt_lz;
         end
      end
   end

   assign bus.active_digit = active_digit_q;
   assign bus.num          = num_q;
   assign bus.dp_ctrl      = dp_ctrl_q;
   assign bus.blank        = blank_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.pending      = pending_q;

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner with a per-digit expected queue fed from a frame model.
module tb_sseg_digit_scanner;
   localparam int RT = 3;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   sseg_digit_scanner_if bus ();

   sseg_digit_scanner #(.REFRESH_TICKS(RT), .DIGITS(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [8:0]  exp_q[$];
   logic [31:0] m_val, s_val;
   logic [7:0]  m_dp, m_en, s_dp, s_en;
   logic        m_pend, m_lzb;
   int unsigned last_cyc;
   logic [2:0]  prev_digit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] exp_entry(input int i);
      logic [3:0] n;
      logic       lz;
      n  = m_val[4*i +: 4];
      lz = m_lzb && (i != 0) && ((m_val >> (4*i)) == 32'd0);
      return {3'(i), n, m_dp[i], ~m_en[i] | lz};
   endfunction

   task automatic model_reset();
      m_val = '0; m_dp = '0; m_en = 8'hFF;
      s_val = '0; s_dp = '0; s_en = 8'hFF;
      m_pend = 1'b0;
   endtask

   task automatic push_frame();
      for (int i = 1; i < 8; i++) exp_q.push_back(exp_entry(i));
      if (m_pend) begin
         m_val = s_val; m_dp = s_dp; m_en = s_en;
         m_pend = 1'b0;
      end
      exp_q.push_back(exp_entry(0));
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en,
                          input logic lzb);
      bus.value = v; bus.dp_mask = dp; bus.en_mask = en; bus.lzb_en = lzb;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      s_val = v; s_dp = dp; s_en = en; m_pend = 1'b1; m_lzb = lzb;
      chk("pending_after_load", bus.pending, 1);
   endtask

   task automatic check_step();
      int guard;
      logic [8:0] e;
      guard = 0;
      while (bus.active_digit === prev_digit && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         chk("step_timeout", guard, 0);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 1, 0);
         return;
      end
      e = exp_q.pop_front();
      chk("digit",      bus.active_digit, e[8:6]);
      chk("num",        bus.num,          e[5:2]);
      chk("dp_ctrl",    bus.dp_ctrl,      e[1]);
      chk("blank",      bus.blank,        e[0]);
      chk("period",     cyc - last_cyc,   RT + 1);
      chk("frame_done", bus.frame_done,   (e[8:6] == 3'd0));
      last_cyc   = cyc;
      prev_digit = bus.active_digit;
   endtask

   task automatic run_frame();
      logic pend_before;
      pend_before = m_pend;
      push_frame();
      for (int k = 0; k < 8; k++) begin
         check_step();
         chk("pending_in_frame", bus.pending, (k < 7) ? pend_before : 1'b0);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_digit",      bus.active_digit, 0);
      chk("rst_num",        bus.num,          0);
      chk("rst_dp",         bus.dp_ctrl,      0);
      chk("rst_blank",      bus.blank,        0);
      chk("rst_frame_done", bus.frame_done,   0);
      chk("rst_pending",    bus.pending,      0);
   endtask

   initial begin
      bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0; bus.en_mask = 8'hFF; bus.lzb_en = 1'b0;
      reset_n = 1'b0;
      model_reset();
      m_lzb = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset_n    = 1'b1;
      last_cyc   = cyc;
      prev_digit = 3'd0;

      // Idle scan from reset
      run_frame();
      run_frame();

      // Mid-frame load shows only after the wrap
      do_load(32'h1234_5678, 8'h01, 8'hFF, 1'b0);
      run_frame();
      run_frame();

      // Leading-zero blanking on and off
      do_load(32'h0000_00A5, 8'h00, 8'hFF, 1'b1);
      run_frame();
      run_frame();
      bus.lzb_en = 1'b0;
      m_lzb      = 1'b0;
      run_frame();

      // Enable mask blanks, DP still driven
      do_load(32'h8765_4321, 8'hF0, 8'h0F, 1'b0);
      run_frame();
      run_frame();

      // All-zero frame with LZB
      do_load(32'h0000_0000, 8'h00, 8'hFF, 1'b1);
      run_frame();
      run_frame();

      // Load in the wrap cycle overrides an earlier pending frame
      do_load(32'hFFFF_FFFF, 8'h00, 8'hFF, 1'b1);
      for (int i = 1; i < 8; i++) exp_q.push_back(exp_entry(i));
      m_val = 32'hCAFE_0001; m_dp = 8'h00; m_en = 8'hFF; m_pend = 1'b0;
      exp_q.push_back(exp_entry(0));
      for (int k = 0; k < 7; k++) begin
         check_step();
         chk("pending_before_wrap", bus.pending, 1);
      end
      repeat (3) @(negedge clk);
      bus.value = 32'hCAFE_0001; bus.dp_mask = 8'h00; bus.en_mask = 8'hFF;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      check_step();
      chk("pending_after_wrap_load", bus.pending, 0);
      run_frame();

      // Asynchronous reset at digit 5 with a pending frame
      do_load(32'h1234_5678, 8'hFF, 8'hFF, 1'b0);
      for (int i = 1; i < 6; i++) exp_q.push_back(exp_entry(i));
      for (int k = 0; k < 5; k++) check_step();
      chk("pre_reset_digit", bus.active_digit, 5);
      chk("pre_reset_pending", bus.pending, 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      model_reset();
      @(negedge clk);
      reset_n    = 1'b1;
      last_cyc   = cyc;
      prev_digit = 3'd0;
      run_frame();

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
